mmap_arbiter: RTL and testbench

Two-port arbiter and sequencer for a single `mmap_region` bus. It sits between the CPU's instruction-fetch and load/store units and the memory-map decode, and grants the bus to one requester at a time with round-robin fairness. It registers the region's data and fault response back to the winning requester. It also latches the first fault (cause and word address) for the trap logic until software clears it.

---
 rtl/base.sv | 18 +
 rtl/mmap_region.sv | 29 ++
 rtl/fault_latch.sv | 40 ++++
 rtl/mmap_arbiter.sv | 144 ++++++++++++++
 tb/tb_mmap_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/base.sv
// Shared types and constants for the CPU-side memory-map path.
package base;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

  typedef logic [1:0] arb_state_e;
  localparam arb_state_e IDLE   = 2'd0;
  localparam arb_state_e ACCESS = 2'd1;
  localparam arb_state_e RESP   = 2'd2;

  localparam logic [2:0] FAULT_EXEC  = 3'b100;
  localparam logic [2:0] FAULT_READ  = 3'b010;
  localparam logic [2:0] FAULT_WRITE = 3'b001;

endpackage

// File: rtl/mmap_region.sv
// Bus between the CPU-side arbiter and a memory-map region decoder.
interface mmap_region #(
  parameter int unsigned ADDR_W = 22
);
  logic              request_exec;
  logic              rw_request;
  logic              is_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       write_word;
  logic [31:0]       exec_word;
  logic [31:0]       read_word;
  logic              word_level_io;
  logic              fault_exec;
  logic              fault_read;
  logic              fault_write;
  logic              fault_einval;

  modport CPU (
    output request_exec, rw_request, is_write, addr, write_word,
    input  exec_word, read_word, word_level_io,
    input  fault_exec, fault_read, fault_write, fault_einval
  );

  modport REGION (
    input  request_exec, rw_request, is_write, addr, write_word,
    output exec_word, read_word, word_level_io,
    output fault_exec, fault_read, fault_write, fault_einval
  );
endinterface

// File: rtl/fault_latch.sv
// First-fault-wins cause/address latch; a capture coinciding with a clear is kept.
module fault_latch #(
  parameter int unsigned ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [2:0]        new_cause,
  input  logic [ADDR_W-1:0] new_addr,
  output logic              pending,
  output logic [2:0]        cause,
  output logic [ADDR_W-1:0] addr
);

  logic              pending_q;
  logic [2:0]        cause_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      cause_q   <= '0;
      addr_q    <= '0;
    end else if (capture && (!pending_q || clear)) begin
      pending_q <= 1'b1;
      cause_q   <= new_cause;
      addr_q    <= new_addr;
    end else if (clear) begin
      pending_q <= 1'b0;
      cause_q   <= '0;
      addr_q    <= '0;
    end
  end

  assign pending = pending_q;
  assign cause   = cause_q;
  assign addr    = addr_q;

endmodule

// File: rtl/mmap_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for one mmap_region bus.
module mmap_arbiter
  import base::*;
#(
  parameter int unsigned ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_word,
  output logic              fetch_fault,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_valid,
  output logic [31:0]       data_rdata,
  output logic              data_fault,
  output logic              fault_pending,
  output logic [2:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clear,
  mmap_region.CPU           bus
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, op_port_q, grant_port;
  logic [ADDR_W-1:0] op_addr_q;
  logic              op_we_q;
  logic [31:0]       op_wdata_q;
  logic [31:0]       fetch_word_q, data_rdata_q;
  logic              fetch_fault_q, data_fault_q;
  logic              access_fault, capture;
  logic [2:0]        access_cause;
  logic              unused_word_level_io;

  assign unused_word_level_io = bus.word_level_io;

  // On a tie the port that lost last time wins.
  assign grant_port = (fetch_req && (!data_req || last_grant_q == DATA)) ? FETCH : DATA;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_req || data_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.request_exec = 1'b0;
    bus.rw_request   = 1'b0;
    bus.is_write     = 1'b0;
    bus.addr         = '0;
    bus.write_word   = '0;
    if (state_q == ACCESS) begin
      bus.addr = op_addr_q;
      if (op_port_q == FETCH) begin
        bus.request_exec = 1'b1;
      end else begin
        bus.rw_request = 1'b1;
        bus.is_write   = op_we_q;
        bus.write_word = op_we_q ? op_wdata_q : '0;
      end
    end
  end

  // einval is exec-class for fetches and read-class for data accesses.
  always_comb begin
    if (op_port_q == FETCH) begin
      access_fault = bus.fault_exec | bus.fault_einval;
      access_cause = FAULT_EXEC;
    end else begin
      access_fault = bus.fault_read | bus.fault_write | bus.fault_einval;
      access_cause = (bus.fault_read | bus.fault_einval) ? FAULT_READ : FAULT_WRITE;
    end
  end

  assign capture = (state_q == ACCESS) && access_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= DATA;
      op_port_q     <= FETCH;
      op_addr_q     <= '0;
      op_we_q       <= 1'b0;
      op_wdata_q    <= '0;
      fetch_word_q  <= '0;
      fetch_fault_q <= 1'b0;
      data_rdata_q  <= '0;
      data_fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (fetch_req || data_req)) begin
        op_port_q <= grant_port;
        if (grant_port == FETCH) begin
          op_addr_q  <= fetch_addr;
          op_we_q    <= 1'b0;
          op_wdata_q <= '0;
        end else begin
          op_addr_q  <= data_addr;
          op_we_q    <= data_we;
          op_wdata_q <= data_wdata;
        end
      end
      if (state_q == ACCESS) begin
        last_grant_q <= op_port_q;
        if (op_port_q == FETCH) begin
          fetch_word_q  <= bus.exec_word;
          fetch_fault_q <= access_fault;
        end else begin
          data_rdata_q <= (op_we_q || access_fault) ? '0 : bus.read_word;
          data_fault_q <= access_fault;
        end
      end
    end
  end

  assign fetch_valid = (state_q == RESP) && (op_port_q == FETCH);
  assign data_valid  = (state_q == RESP) && (op_port_q == DATA);
  assign fetch_word  = fetch_word_q;
  assign fetch_fault = fetch_fault_q;
  assign data_rdata  = data_rdata_q;
  assign data_fault  = data_fault_q;

  fault_latch #(
    .ADDR_W (ADDR_W)
  ) u_fault_latch (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .clear     (fault_clear),
    .new_cause (access_cause),
    .new_addr  (op_addr_q),
    .pending   (fault_pending),
    .cause     (fault_cause),
    .addr      (fault_addr)
  );

endmodule

// File: tb/tb_mmap_arbiter.sv
// Directed and randomized bench for mmap_arbiter with a simple region device model.
module tb_mmap_arbiter;
  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, fetch_valid, fetch_fault;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_word;
  logic          data_req, data_we, data_valid, data_fault;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          fault_pending, fault_clear;
  logic [2:0]    fault_cause;
  logic [AW-1:0] fault_addr;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mmap_region #(.ADDR_W(AW)) bus_if ();

  mmap_arbiter #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_word    (fetch_word),
    .fetch_fault   (fetch_fault),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_valid    (data_valid),
    .data_rdata    (data_rdata),
    .data_fault    (data_fault),
    .fault_pending (fault_pending),
    .fault_cause   (fault_cause),
    .fault_addr    (fault_addr),
    .fault_clear   (fault_clear),
    .bus           (bus_if)
  );

  // Region device: addr[9:8] picks the region kind
  // 0 normal, 1 read-only, 2 zero-backed (no exec/read/write), 3 einval.
  logic [31:0] dev_mem [64];
  logic [1:0]  dev_kind;
  logic [5:0]  dev_idx;
  assign dev_kind = bus_if.addr[9:8];
  assign dev_idx  = bus_if.addr[5:0];

  function automatic logic [31:0] mem_init(input int i);
    return 32'(32'h9E37_79B9 * (i + 1));
  endfunction

  always_comb begin
    bus_if.exec_word     = '0;
    bus_if.read_word     = '0;
    bus_if.word_level_io = 1'b1;
    bus_if.fault_exec    = 1'b0;
    bus_if.fault_read    = 1'b0;
    bus_if.fault_write   = 1'b0;
    bus_if.fault_einval  = 1'b0;
    if (bus_if.request_exec) begin
      if (dev_kind == 2'd2)      bus_if.fault_exec   = 1'b1;
      else if (dev_kind == 2'd3) bus_if.fault_einval = 1'b1;
      else                       bus_if.exec_word    = dev_mem[dev_idx];
    end
    if (bus_if.rw_request) begin
      if (dev_kind == 2'd3) bus_if.fault_einval = 1'b1;
      else if (bus_if.is_write) bus_if.fault_write = (dev_kind != 2'd0);
      else if (dev_kind == 2'd2) bus_if.fault_read = 1'b1;
      else bus_if.read_word = dev_mem[dev_idx];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= mem_init(i);
    end else if (bus_if.rw_request && bus_if.is_write && !bus_if.fault_write &&
                 !bus_if.fault_einval) begin
      dev_mem[dev_idx] <= bus_if.write_word;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    fault_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issues one request from IDLE and watches the three cycles that follow.
  task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [31:0] wd, input bit clr_mid,
                        output logic [2:0] vseq, output logic [2:0] rwseq,
                        output logic [2:0] exseq, output logic [2:0] iwseq,
                        output logic [31:0] word, output logic flt);
    if (!p) begin
      fetch_req = 1'b1; fetch_addr = a;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
    end
    word = '0;
    flt  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vseq[k]  = p ? data_valid : fetch_valid;
      rwseq[k] = bus_if.rw_request;
      exseq[k] = bus_if.request_exec;
      iwseq[k] = bus_if.is_write;
      if (k == 2) begin
        word = p ? data_rdata : fetch_word;
        flt  = p ? data_fault : fetch_fault;
      end
      @(posedge clk); #1;
      if (k == 0) fault_clear = clr_mid;
      if (k == 1) fault_clear = 1'b0;
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
  endtask

  task automatic check_latch(input string tag, input logic [25:0] exp);
    @(negedge clk);
    check_eq(tag, {fault_pending, fault_cause, fault_addr}, exp);
    @(posedge clk); #1;
  endtask

  // Reference model for the random phase.
  logic [31:0] model_mem [64];

  task automatic ref_access(input bit p, input bit we, input logic [AW-1:0] a,
                            input logic [31:0] wd, output logic [31:0] word,
                            output bit flt, output logic [2:0] cause);
    int kind = int'(a[9:8]);
    int idx  = int'(a[5:0]);
    if (!p) begin
      flt   = (kind >= 2);
      cause = 3'b100;
      word  = flt ? 32'h0 : model_mem[idx];
    end else if (!we) begin
      flt   = (kind >= 2);
      cause = 3'b010;
      word  = flt ? 32'h0 : model_mem[idx];
    end else begin
      flt   = (kind != 0);
      cause = (kind == 3) ? 3'b010 : 3'b001;
      word  = 32'h0;
      if (!flt) model_mem[idx] = wd;
    end
  endtask

  logic [2:0]  vs, rws, exs, iws;
  logic [31:0] w;
  logic        f;
  logic [11:0] fv, dv;

  initial begin
    do_reset();
    @(negedge clk);
    check_eq("rst_valid", {fetch_valid, data_valid}, 2'b00);
    check_eq("rst_words", {fetch_word, data_rdata}, 64'h0);
    check_eq("rst_faults", {fetch_fault, data_fault, fault_pending, fault_cause}, 6'h0);
    check_eq("rst_fault_addr", fault_addr, 22'h0);
    check_eq("rst_bus", {bus_if.request_exec, bus_if.rw_request, bus_if.is_write,
                         bus_if.write_word, bus_if.addr}, 57'h0);
    @(posedge clk); #1;

    access(1'b1, 1'b1, 22'h010, 32'hDEAD_BEEF, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("store_valid_seq", vs, 3'b100);
    check_eq("store_resp", {w, f}, 33'h0);
    check_eq("store_bus_seq", {rws, iws, exs}, 9'b010_010_000);

    access(1'b0, 1'b0, 22'h010, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("fetch_valid_seq", vs, 3'b100);
    check_eq("fetch_resp", {w, f}, {32'hDEAD_BEEF, 1'b0});
    check_eq("fetch_bus_seq", {exs, rws}, 6'b010_000);

    access(1'b1, 1'b1, 22'h020, 32'hA5A5_A5A5, 1'b0, vs, rws, exs, iws, w, f);
    access(1'b1, 1'b0, 22'h020, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("load_valid_seq", vs, 3'b100);
    check_eq("load_resp", {w, f}, {32'hA5A5_A5A5, 1'b0});
    check_eq("load_bus_seq", {rws, iws, exs}, 9'b010_000_000);

    // Both ports held: last winner was DATA, so FETCH goes first.
    fetch_req = 1'b1; fetch_addr = 22'h010;
    data_req = 1'b1; data_we = 1'b0; data_addr = 22'h020;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      fv[k] = fetch_valid;
      dv[k] = data_valid;
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; data_req = 1'b0;
    check_eq("tie_fetch_valids", fv, 12'h104);
    check_eq("tie_data_valids", dv, 12'h820);
    check_eq("tie_words", {fetch_word, data_rdata}, {32'hDEAD_BEEF, 32'hA5A5_A5A5});

    access(1'b1, 1'b1, 22'h123, 32'h1111_2222, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("wfault_resp", {vs, w, f}, {3'b100, 32'h0, 1'b1});
    check_latch("wfault_latch", {1'b1, 3'b001, 22'h123});
    access(1'b1, 1'b0, 22'h200, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("rfault_resp", {vs, w, f}, {3'b100, 32'h0, 1'b1});
    check_latch("rfault_keeps_first", {1'b1, 3'b001, 22'h123});

    fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
    check_latch("clear_latch", 26'h0);

    access(1'b0, 1'b0, 22'h210, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    check_eq("xfault_resp", {vs, w, f}, {3'b100, 32'h0, 1'b1});
    check_latch("xfault_latch", {1'b1, 3'b100, 22'h210});
    access(1'b1, 1'b0, 22'h200, 32'h0, 1'b1, vs, rws, exs, iws, w, f);
    check_latch("capture_beats_clear", {1'b1, 3'b010, 22'h200});

    fault_clear = 1'b1;
    @(posedge clk); #1 fault_clear = 1'b0;
    access(1'b0, 1'b0, 22'h010, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    access(1'b1, 1'b0, 22'h020, 32'h0, 1'b0, vs, rws, exs, iws, w, f);
    // Faulting load aborted by reset in its ACCESS cycle.
    data_req = 1'b1; data_we = 1'b0; data_addr = 22'h300;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check_eq("abort_no_valid", {fetch_valid, data_valid}, 2'b00);
    check_eq("abort_latch", {fault_pending, fault_cause, fault_addr}, 26'h0);
    check_eq("abort_words", {fetch_word, data_rdata, fetch_fault, data_fault}, 66'h0);
    check_eq("abort_bus", {bus_if.request_exec, bus_if.rw_request, bus_if.write_word}, 34'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_no_late_valid", {fetch_valid, data_valid}, 2'b00);

    begin
      bit          outst [2];
      logic [AW-1:0] r_addr [2];
      bit          r_we [2];
      logic [31:0] r_wd [2];
      int          free_cyc = 0, resp_cyc = -10;
      bit          last_p = 1'b1, exp_port = 1'b0, gp, exp_fault = 1'b0, clr_prev = 1'b0;
      logic [31:0] exp_word = '0;
      logic [2:0]  exp_cause = '0, m_cause = '0;
      logic [AW-1:0] exp_addr = '0, m_faddr = '0;
      logic        m_pend = 1'b0;

      do_reset();
      for (int i = 0; i < 64; i++) model_mem[i] = mem_init(i);
      for (int p = 0; p < 2; p++) begin
        outst[p] = 1'b0; r_addr[p] = '0; r_we[p] = 1'b0; r_wd[p] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clk); #1;
        if (cyc == resp_cyc && exp_fault) begin
          if (!m_pend || clr_prev) begin
            m_pend = 1'b1; m_cause = exp_cause; m_faddr = exp_addr;
          end
        end else if (clr_prev) begin
          m_pend = 1'b0; m_cause = '0; m_faddr = '0;
        end
        for (int p = 0; p < 2; p++) begin
          if (!outst[p] && $urandom_range(0, 2) != 0) begin
            outst[p]  = 1'b1;
            r_addr[p] = AW'($urandom_range(0, 1023));
            r_we[p]   = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_wd[p]   = $urandom;
          end
        end
        fetch_req = outst[0]; fetch_addr = r_addr[0];
        data_req = outst[1]; data_we = r_we[1]; data_addr = r_addr[1]; data_wdata = r_wd[1];
        fault_clear = ($urandom_range(0, 9) == 0);
        if (cyc >= free_cyc && (outst[0] || outst[1])) begin
          gp = (outst[0] && outst[1]) ? !last_p : outst[1];
          last_p   = gp;
          exp_port = gp;
          exp_addr = r_addr[gp];
          resp_cyc = cyc + 2;
          free_cyc = cyc + 3;
          ref_access(gp, r_we[gp], r_addr[gp], r_wd[gp], exp_word, exp_fault, exp_cause);
        end
        @(negedge clk);
        check_eq("rnd_valid", {fetch_valid, data_valid},
                 (cyc == resp_cyc) ? (exp_port ? 2'b01 : 2'b10) : 2'b00);
        if (cyc == resp_cyc) begin
          check_eq("rnd_word", exp_port ? data_rdata : fetch_word, exp_word);
          check_eq("rnd_fault", exp_port ? data_fault : fetch_fault, exp_fault);
          outst[exp_port] = 1'b0;
        end
        check_eq("rnd_latch", {fault_pending, fault_cause, fault_addr},
                 {m_pend, m_cause, m_faddr});
        clr_prev = fault_clear;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
